// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared stall-bus patterns and controller state encodings.
// Imported by pipe_stall_ctrl and stall_wait_counter.
package pipe_stall_ctrl_pkg;

  localparam int STALL_BUS_W = 6;

  typedef logic [STALL_BUS_W-1:0] stall_bus_t;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  // bit 0 = PC ... bit 5 = WB
  localparam stall_bus_t STALL_NONE = 6'b000000;
  localparam stall_bus_t STALL_ID   = 6'b000111;
  localparam stall_bus_t STALL_EX   = 6'b001111;
  localparam stall_bus_t STALL_MEM  = 6'b011111;

  typedef enum logic [1:0] {
    CTRL_IDLE = 2'd0,
    CTRL_LU   = 2'd1,
    CTRL_EXW  = 2'd2,
    CTRL_MEMW = 2'd3
  } ctrl_state_e;

  // The state a request moves the FSM into also names
  // the pattern it drives this cycle.
  function automatic stall_bus_t stall_pattern(
    input ctrl_state_e s
  );
    stall_bus_t p;
    p = STALL_NONE;
    unique case (s)
      CTRL_LU:   p = STALL_ID;
      CTRL_EXW:  p = STALL_EX;
      CTRL_MEMW: p = STALL_MEM;
      default:   p = STALL_NONE;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/stall_wait_counter.sv
// Watchdog for EX multi-cycle waits: counts consecutive busy
// cycles (saturating) and raises a sticky flag at EX_TIMEOUT.
// Ports: clk, rst (async high), inc_i (busy), flag_o (sticky).
module stall_wait_counter
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int CNT_W      = 7,
  parameter int EX_TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  output logic flag_o
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(EX_TIMEOUT);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flag_q, flag_d;

  always_comb begin
    cnt_d  = '0;
    flag_d = flag_q;
    if (inc_i) begin
      cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    end
    // flag rises on the same edge the count lands on LIMIT
    if (cnt_d >= LIMIT) begin
      flag_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      flag_q <= flag_d;
    end
  end

  assign flag_o = flag_q;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central stall sequencer: arbitrates ID/EX/MEM stall requests
// (MEM > EX > ID) and drives the shared stall bus.
// Ports: clk, rst (async high), stallreq_for_{id_if,ex,mem},
// stall[STALL_W], ctrl_state[2], ex_timeout (sticky).
// Macro STALL_PERF_CNT_EN adds perf_{lu,ex,mem}_cnt[32].
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int STALL_W    = 6,
  parameter int EX_TIMEOUT = 64,
  parameter int CNT_W      = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stallreq_for_id_if,
  input  logic               stallreq_for_ex,
  input  logic               stallreq_for_mem,
  output logic [STALL_W-1:0] stall,
  output logic [1:0]         ctrl_state,
  output logic               ex_timeout
`ifdef STALL_PERF_CNT_EN
  ,
  output logic [31:0]        perf_lu_cnt,
  output logic [31:0]        perf_ex_cnt,
  output logic [31:0]        perf_mem_cnt
`endif
);

  ctrl_state_e state_q, state_d;
  logic        id_masked;
  logic        win_mem, win_ex, win_id;
  stall_bus_t  pattern;

  // One hazard yields one bubble: the ID request is ignored
  // during the bubble cycle itself.
  assign id_masked = (state_q == CTRL_LU);

  assign win_mem = stallreq_for_mem;
  assign win_ex  = stallreq_for_ex & ~stallreq_for_mem;
  assign win_id  = stallreq_for_id_if & ~id_masked
                 & ~stallreq_for_ex & ~stallreq_for_mem;

  always_comb begin
    state_d = CTRL_IDLE;
    unique case (1'b1)
      win_mem: state_d = CTRL_MEMW;
      win_ex:  state_d = CTRL_EXW;
      win_id:  state_d = CTRL_LU;
      default: state_d = CTRL_IDLE;
    endcase
  end

  // Mealy output: the winning request stalls this cycle.
  assign pattern = stall_pattern(state_d);
  assign stall   = rst ? '0 : STALL_W'(pattern);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CTRL_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign ctrl_state = state_q;

  stall_wait_counter #(
    .CNT_W      (CNT_W),
    .EX_TIMEOUT (EX_TIMEOUT)
  ) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .inc_i  (stallreq_for_ex),
    .flag_o (ex_timeout)
  );

`ifdef STALL_PERF_CNT_EN
  logic [31:0] perf_lu_q, perf_ex_q, perf_mem_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_lu_q  <= '0;
      perf_ex_q  <= '0;
      perf_mem_q <= '0;
    end else begin
      if (win_id)  perf_lu_q  <= perf_lu_q + 32'd1;
      if (win_ex)  perf_ex_q  <= perf_ex_q + 32'd1;
      if (win_mem) perf_mem_q <= perf_mem_q + 32'd1;
    end
  end

  assign perf_lu_cnt  = perf_lu_q;
  assign perf_ex_cnt  = perf_ex_q;
  assign perf_mem_cnt = perf_mem_q;
`endif

endmodule
